gpio_responder: RTL and testbench

- Memory-mapped GPIO peripheral on the bus side the address decoder drives. It is the responder for CPU loads and stores that the decoder steers to GPIO.
- Holds the LED output register. Synchronises and debounces the switch inputs, and returns read data to the CPU data path.
- Sits beside the data RAM. Its read data is muxed with RAM read data by the decoder's GPIO select.

---
 rtl/gpio_responder_if.sv | 19 +
 rtl/gpio_responder.sv | 86 ++++++++
 tb/tb_gpio_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_responder_if.sv
// CPU data-bus signals between the address decoder / CPU (master) and the GPIO responder (slave).
interface gpio_responder_if;
   logic [31:0] Address_i;
   logic        Mem_write_i;
   logic        Mem_read_i;
   logic        selector_gpio_i;
   logic [31:0] Write_data_i;
   logic [31:0] Read_data_o;

   modport master (
      output Address_i, Mem_write_i, Mem_read_i, selector_gpio_i, Write_data_i,
      input  Read_data_o
   );

   modport slave (
      input  Address_i, Mem_write_i, Mem_read_i, selector_gpio_i, Write_data_i,
      output Read_data_o
   );
endinterface

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO responder: LED output register, synchronised + debounced switch inputs.
// Optional input-change interrupt flag enabled by defining GPIO_IRQ_EN.
module gpio_responder #(
   parameter int unsigned WIDTH           = 8,
   parameter logic [31:0] ADDR_OUT        = 32'h10010024,
   parameter logic [31:0] ADDR_IN         = 32'h10010028,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   gpio_responder_if.slave  bus,
   input  logic [WIDTH-1:0] gpio_in_i,
   output logic [WIDTH-1:0] gpio_out_o,
   output logic             irq_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_gpio_out;
   logic [CW-1:0]    r_cnt;

   logic w_wr_hit;
   logic w_rd_hit;
   logic w_unused_wdata;

   assign w_wr_hit = bus.selector_gpio_i && bus.Mem_write_i && (bus.Address_i == ADDR_OUT);
   assign w_rd_hit = bus.selector_gpio_i && bus.Mem_read_i && (bus.Address_i == ADDR_IN);

   // Upper store-data bits have no destination.
   assign w_unused_wdata = ^bus.Write_data_i;

   assign bus.Read_data_o = w_rd_hit ? 32'(r_stable) : 32'h0;
   assign gpio_out_o      = r_gpio_out;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_stable   <= '0;
         r_cnt      <= '0;
         r_gpio_out <= '0;
      end else begin
         r_sync1 <= gpio_in_i;
         r_sync2 <= r_sync1;
         if (w_wr_hit) begin
            r_gpio_out <= bus.Write_data_i[WIDTH-1:0];
         end
         // One counter for the whole vector: any return to stable restarts the count.
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CntMax) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef GPIO_IRQ_EN
   logic w_stable_chg;
   logic r_irq;

   assign w_stable_chg = (r_sync2 != r_stable) && (r_cnt == CntMax);

   // Set has priority over the read-clear so a change coinciding with a load is not lost.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_irq <= 1'b0;
      end else if (w_stable_chg) begin
         r_irq <= 1'b1;
      end else if (w_rd_hit) begin
         r_irq <= 1'b0;
      end
   end

   assign irq_o = r_irq;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_responder.sv
// Directed, table-driven bench for gpio_responder with DEBOUNCE_CYCLES = 4.
module tb_gpio_responder;

   localparam logic [31:0] AOut = 32'h10010024;
   localparam logic [31:0] AIn  = 32'h10010028;
`ifdef GPIO_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] gpio_in = 8'h00;
   logic [7:0] gpio_out;
   logic       irq;
   int         n_err = 0;
   int         n_chk = 0;

   gpio_responder_if bus ();

   gpio_responder #(
      .WIDTH           (8),
      .ADDR_OUT        (AOut),
      .ADDR_IN         (AIn),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .bus        (bus),
      .gpio_in_i  (gpio_in),
      .gpio_out_o (gpio_out),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic        rd;
      logic        sel;
      logic [31:0] wdata;
      logic [7:0]  exp_out;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic w, input logic r, input logic s,
                        input logic [31:0] d);
      bus.Address_i       = a;
      bus.Mem_write_i     = w;
      bus.Mem_read_i      = r;
      bus.selector_gpio_i = s;
      bus.Write_data_i    = d;
   endtask

   vec_t vecs[11];

   initial begin
      // Stable is 0x42 when the table runs.
      vecs[0]  = '{AOut, 1, 0, 1, 32'hDEADBEA5, 8'hA5, 32'h0};
      vecs[1]  = '{AOut, 1, 0, 0, 32'h00000011, 8'hA5, 32'h0};
      vecs[2]  = '{AIn,  1, 0, 1, 32'h00000022, 8'hA5, 32'h0};
      vecs[3]  = '{AOut, 0, 1, 1, 32'h0,        8'hA5, 32'h0};
      vecs[4]  = '{AIn,  0, 1, 1, 32'h0,        8'hA5, 32'h42};
      vecs[5]  = '{AIn,  0, 1, 0, 32'h0,        8'hA5, 32'h0};
      vecs[6]  = '{AOut, 1, 1, 1, 32'h0000005A, 8'h5A, 32'h0};
      vecs[7]  = '{AIn,  1, 1, 1, 32'h00000077, 8'h5A, 32'h42};
      vecs[8]  = '{AOut, 1, 0, 1, 32'h000001FF, 8'hFF, 32'h0};
      vecs[9]  = '{32'h1001002C, 0, 1, 1, 32'h0, 8'hFF, 32'h0};
      vecs[10] = '{AOut, 1, 0, 1, 32'hFFFFFFA5, 8'hA5, 32'h0};

      drive(32'h0, 0, 0, 0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out", 32'(gpio_out), 32'h0);
      chk("rst_rd", bus.Read_data_o, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_out", 32'(gpio_out), 32'h0);
      chk("idle_rd", bus.Read_data_o, 32'h0);
      chk("idle_irq", 32'(irq), 32'h0);

      // Debounce 0x00 -> 0x3C while loading every cycle.
      gpio_in = 8'h3C;
      drive(AIn, 0, 1, 1, 32'h0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("deb_rd_e%0d", k), bus.Read_data_o, (k >= 6) ? 32'h3C : 32'h0);
         chk($sformatf("deb_irq_e%0d", k), 32'(irq), 32'((k == 6) && IrqEn));
      end
      drive(AOut, 0, 1, 1, 32'h0);
      #1 chk("rd_addr_out", bus.Read_data_o, 32'h0);

      // Two-cycle glitch to 0xFF must be rejected.
      drive(AIn, 0, 1, 1, 32'h0);
      gpio_in = 8'hFF;
      tick();
      tick();
      gpio_in = 8'h3C;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("glitch_rd_%0d", k), bus.Read_data_o, 32'h3C);
      end
      chk("glitch_cnt", 32'(dut.r_cnt), 32'h0);
      chk("glitch_irq", 32'(irq), 32'h0);

      // Input-change interrupt: set, read-clear, and set winning over clear.
      drive(AIn, 0, 0, 1, 32'h0);
      gpio_in = 8'h81;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("irq1_e%0d", k), 32'(irq), 32'((k == 6) && IrqEn));
      end
      bus.Mem_read_i = 1'b1;
      #1 chk("irq1_rd", bus.Read_data_o, 32'h81);
      tick();
      chk("irq_clr", 32'(irq), 32'h0);
      bus.Mem_read_i = 1'b0;
      gpio_in = 8'h42;
      for (int k = 1; k <= 5; k++) tick();
      chk("irq2_pre", 32'(irq), 32'h0);
      bus.Mem_read_i = 1'b1;
      #1 chk("irq2_rd_old", bus.Read_data_o, 32'h81);
      tick();
      chk("irq2_setwins", 32'(irq), 32'(IrqEn));
      chk("irq2_rd_new", bus.Read_data_o, 32'h42);
      bus.Mem_read_i = 1'b0;
      tick();
      chk("irq2_hold", 32'(irq), 32'(IrqEn));
      bus.Mem_read_i = 1'b1;
      tick();
      chk("irq2_clr", 32'(irq), 32'h0);

      // Bus vector table.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].sel, vecs[i].wdata);
         #1 chk($sformatf("vec%0d_rd", i), bus.Read_data_o, vecs[i].exp_rd);
         tick();
         chk($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      end

      // Asynchronous reset mid-debounce, then full re-debounce from zero.
      drive(AIn, 0, 1, 1, 32'h0);
      gpio_in = 8'h0F;
      tick();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", 32'(gpio_out), 32'h0);
      chk("arst_rd", bus.Read_data_o, 32'h0);
      chk("arst_irq", 32'(irq), 32'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("rdeb_rd_e%0d", k), bus.Read_data_o, (k == 6) ? 32'h0F : 32'h0);
      end
      chk("rdeb_irq", 32'(irq), 32'(IrqEn));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
